// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end fetch sequencer.
// It owns the PC and drives the I-MEM read address. Fetched words are
// buffered in a QDEPTH-entry queue, so fetch keeps going while DE stalls.
// A taken branch from AGEX redirects fetch and flushes the queue.
//
// Ports:
//   clk, reset_n                  clock (rising edge), async active-low reset
//   redirect_valid, redirect_pc   AGEX branch redirect request and its target
//   de_ready                      DE accepts the head entry this cycle
//   imem_addr / imem_rdata        I-MEM byte address (= PC) and the word read there (combinational)
//   out_valid, out_inst, out_pc,  head entry toward DE
//   out_pcplus, out_inst_count
//   fq_level                      queue occupancy, 0..QDEPTH
//   fe_state                      FSM state (0 BOOT, 1 FETCH, 2 HOLD)
//   align_err                     sticky: a misaligned redirect was seen
//
// Optional macro FETCH_PERF_EN adds three saturating 32-bit counters:
//   perf_fetched  push cycles
//   perf_flushed  sum of fq_level over all redirects
//   perf_stall    cycles spent in HOLD
//
// state | meaning
// BOOT  | first cycle after reset, no fetch
// FETCH | fetching one word per cycle while the queue has room
// HOLD  | queue full and DE stalled; PC and inst_count held
module fetch_ctrl #(
  parameter int               DBITS    = 32,
  parameter int               INSTBITS = 32,
  parameter int               QDEPTH   = 4,
  parameter logic [DBITS-1:0] STARTPC  = 'h100,
  parameter int               INSTSIZE = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      redirect_valid,
  input  logic [DBITS-1:0]          redirect_pc,
  input  logic                      de_ready,
  output logic [DBITS-1:0]          imem_addr,
  input  logic [INSTBITS-1:0]       imem_rdata,
  output logic                      out_valid,
  output logic [INSTBITS-1:0]       out_inst,
  output logic [DBITS-1:0]          out_pc,
  output logic [DBITS-1:0]          out_pcplus,
  output logic [DBITS-1:0]          out_inst_count,
  output logic [$clog2(QDEPTH):0]   fq_level,
  output logic [1:0]                fe_state,
  output logic                      align_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_flushed,
  output logic [31:0]               perf_stall
`endif
);

  localparam int AW = $clog2(QDEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    L_FULL = LW'(QDEPTH);
  localparam logic [DBITS-1:0] L_INC  = DBITS'(INSTSIZE);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t r_state, w_next_state;

  logic [DBITS-1:0]    r_pc;
  logic [DBITS-1:0]    r_cnt;
  logic [LW-1:0]       r_level;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic                r_align_err;

  logic [INSTBITS-1:0] r_q_inst   [QDEPTH];
  logic [DBITS-1:0]    r_q_pc     [QDEPTH];
  logic [DBITS-1:0]    r_q_pcplus [QDEPTH];
  logic [DBITS-1:0]    r_q_cnt    [QDEPTH];

  logic                w_out_valid;
  logic                w_pop;
  logic                w_push;
  logic [DBITS-1:0]    w_pcplus;
  logic [DBITS-1:0]    w_redirect_pc;

  // A redirect cycle blanks the output, so nothing is popped during a flush.
  assign w_out_valid   = (r_level != '0) & ~redirect_valid;
  assign w_pop         = w_out_valid & de_ready;
  // When the queue is full, a push is allowed only if the head leaves in the same cycle.
  assign w_push        = (r_state != S_BOOT) & ~redirect_valid & ((r_level != L_FULL) | w_pop);
  assign w_pcplus      = r_pc + L_INC;
  assign w_redirect_pc = {redirect_pc[DBITS-1:2], 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT:  w_next_state = S_FETCH;
      S_FETCH: if ((r_level == L_FULL) && !w_pop) w_next_state = S_HOLD;
      S_HOLD:  if (w_pop) w_next_state = S_FETCH;
      default: w_next_state = S_BOOT;
    endcase
    if (redirect_valid) w_next_state = S_FETCH;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc        <= STARTPC;
      r_cnt       <= DBITS'(1);
      r_align_err <= 1'b0;
    end else if (redirect_valid) begin
      r_pc  <= w_redirect_pc;
      r_cnt <= r_cnt + DBITS'(1);
      if (redirect_pc[1:0] != 2'b00) r_align_err <= 1'b1;
    end else if (w_push) begin
      r_pc  <= w_pcplus;
      r_cnt <= r_cnt + DBITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_inst[i]   <= '0;
        r_q_pc[i]     <= '0;
        r_q_pcplus[i] <= '0;
        r_q_cnt[i]    <= '0;
      end
    end else if (redirect_valid) begin
      r_level <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_q_inst[r_wptr]   <= imem_rdata;
        r_q_pc[r_wptr]     <= r_pc;
        r_q_pcplus[r_wptr] <= w_pcplus;
        r_q_cnt[r_wptr]    <= r_cnt;
        r_wptr             <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign imem_addr      = r_pc;
  assign out_valid      = w_out_valid;
  assign out_inst       = r_q_inst[r_rptr];
  assign out_pc         = r_q_pc[r_rptr];
  assign out_pcplus     = r_q_pcplus[r_rptr];
  assign out_inst_count = r_q_cnt[r_rptr];
  assign fq_level       = r_level;
  assign fe_state       = r_state;
  assign align_err      = r_align_err;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;
  logic [31:0] r_perf_stall;
  logic [32:0] w_flush_sum;

  // One bit wider than the counter, so a carry out means saturate.
  assign w_flush_sum = {1'b0, r_perf_flushed} + 33'(r_level);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_push && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (redirect_valid) r_perf_flushed <= w_flush_sum[32] ? '1 : w_flush_sum[31:0];
      if ((r_state == S_HOLD) && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl. A queue-level reference model predicts each entry DE
// should receive. A negedge monitor compares every DUT pop against the
// scoreboard queue.
module tb_fetch_ctrl;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pcplus;
    logic [31:0] cnt;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        de_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus;
  logic [31:0] out_inst_count;
  logic [2:0]  fq_level;
  logic [1:0]  fe_state;
  logic        align_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .de_ready       (de_ready),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pcplus     (out_pcplus),
    .out_inst_count (out_inst_count),
    .fq_level       (fq_level),
    .fe_state       (fe_state),
    .align_err      (align_err)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed),
    .perf_stall     (perf_stall)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the queue contents, the PC and the count, plus the coarse phase (0 boot, 1 fetch, 2 hold).
  ent_t        m_q[$];
  ent_t        exp_q[$];
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_align;
  int unsigned m_pushes, m_flushed, m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  ent_t mon_e;
  always @(negedge clk) begin
    if (reset_n && out_valid && de_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL pop_unexpected: got pc %h expected no entry at %0t", out_pc, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_pc", out_pc, mon_e.pc);
        chk("out_inst", out_inst, mon_e.inst);
        chk("out_pcplus", out_pcplus, mon_e.pcplus);
        chk("out_inst_count", out_inst_count, mon_e.cnt);
      end
    end
  end

  // Called at posedge+1. Reset is asserted between clock edges and released
  // at the next posedge+1.
  task automatic do_reset();
    de_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fq_level", 32'(fq_level), 32'd0);
    chk("rst_fe_state", 32'(fe_state), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h100);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_cnt", out_inst_count, 32'd0);
    chk("rst_align_err", 32'(align_err), 32'd0);
    m_q.delete();
    exp_q.delete();
    m_state   = 0;
    m_pc      = 32'h100;
    m_cnt     = 32'd1;
    m_align   = 1'b0;
    m_pushes  = 0;
    m_flushed = 0;
    m_stall   = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Drive one cycle, check the visible state against the model, then advance the model.
  task automatic cycle(input logic dr, input logic rv, input logic [31:0] rp);
    ent_t e;
    bit   pop, push;
    int   lvl;
    de_ready       = dr;
    redirect_valid = rv;
    redirect_pc    = rp;
    #1;
    lvl = m_q.size();
    chk("fq_level", 32'(fq_level), 32'(lvl));
    chk("imem_addr", imem_addr, m_pc);
    chk("fe_state", 32'(fe_state), 32'(m_state));
    chk("align_err", 32'(align_err), 32'(m_align));
    chk("out_valid", 32'(out_valid), 32'(lvl != 0 && !rv));
    if (m_state == 2) m_stall++;
    pop = (lvl != 0) && !rv && dr;
    if (pop) begin
      exp_q.push_back(m_q[0]);
      void'(m_q.pop_front());
    end
    if (rv) begin
      m_flushed += lvl;
      m_q.delete();
      m_pc = {rp[31:2], 2'b00};
      m_cnt++;
      if (rp[1:0] != 2'b00) m_align = 1'b1;
      m_state = 1;
    end else begin
      push = (m_state != 0) && (lvl < 4 || pop);
      if (push) begin
        e.inst   = mem_word(m_pc);
        e.pc     = m_pc;
        e.pcplus = m_pc + 32'd4;
        e.cnt    = m_cnt;
        m_q.push_back(e);
        m_pc += 32'd4;
        m_cnt++;
        m_pushes++;
      end
      if (m_state == 0) m_state = 1;
      else if (m_state == 1 && lvl == 4 && !pop) m_state = 2;
      else if (m_state == 2 && pop) m_state = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n        = 1'b0;
    de_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(posedge clk);
    #1;

    // Straight-line fetch with DE always ready
    do_reset();
    repeat (10) cycle(1'b1, 1'b0, 32'h0);

    // Fill to full, then release back-pressure
    do_reset();
    repeat (8) cycle(1'b0, 1'b0, 32'h0);
    chk("t2_hold_pc", imem_addr, 32'h110);
    chk("t2_hold_state", 32'(fe_state), 32'd2);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Redirect with three entries queued
    do_reset();
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    chk("t3_level_before", 32'(fq_level), 32'd3);
    cycle(1'b1, 1'b1, 32'h240);
    chk("t3_pc_after", imem_addr, 32'h240);
`ifdef FETCH_PERF_EN
    chk("t3_perf_flushed", perf_flushed, 32'd3);
`endif
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Misaligned redirect, a back-to-back redirect, then a PC wrap
    cycle(1'b1, 1'b1, 32'h246);
    chk("t4_pc_aligned", imem_addr, 32'h244);
    chk("t4_align_err", 32'(align_err), 32'd1);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h300);
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);

    // Async reset in mid-stream, then restart
    cycle(1'b0, 1'b0, 32'h0);
    do_reset();
    repeat (5) cycle(1'b1, 1'b0, 32'h0);

    // Random back-pressure and occasional redirects
    for (int i = 0; i < 1000; i++) begin
      logic dr, rv;
      logic [31:0] rp;
      dr = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rv = (i < 600) ? 1'b0 : ($urandom_range(0, 39) == 0);
      rp = 32'h1000 + ($urandom & 32'h0000_0FFF);
      cycle(dr, rv, rp);
    end
`ifdef FETCH_PERF_EN
    chk("perf_flushed", perf_flushed, m_flushed);
    chk("perf_stall", perf_stall, m_stall);
`endif
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_pushes);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
